// File: rtl/max_window_sink_pkg.sv
// Shared definitions for the window-maximum sink: FSM encoding, defaults, result entry layout.
package max_window_sink_pkg;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_CLEAR   = 1'b1;

  localparam int unsigned DEFAULT_W      = 32;
  localparam int unsigned DEFAULT_WINDOW = 100;
  localparam int unsigned DEFAULT_CNT_W  = 7;
  localparam int unsigned DEFAULT_IDX_W  = 16;

  // Result entry at default widths; the FIFO stores {data, idx} in this order.
  typedef struct packed {
    logic [DEFAULT_W-1:0]     data;
    logic [DEFAULT_IDX_W-1:0] idx;
  } res_entry_t;

  // Width of a {data, idx} result entry for arbitrary parameterisation.
  function automatic int unsigned res_entry_w(input int unsigned data_w,
                                              input int unsigned idx_w);
    return data_w + idx_w;
  endfunction

endpackage

// File: rtl/max_result_fifo.sv
// Show-ahead result FIFO: head is always the oldest entry, push-while-full legal with a pop.
module max_result_fifo #(
  parameter int unsigned DW    = 48,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_c,
  output logic          full_c,
  output logic          empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit distinguishes full from empty when the addresses match.
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty_c;
  assign do_push = push & (~full_c | do_pop);
  assign head_c  = mem[rd_ptr[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage; cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/max_window_sink.sv
// Gates the running-max stage, counts samples per window, queues each window maximum
// and clears the max stage with a one-cycle bubble between windows.
module max_window_sink
  import max_window_sink_pkg::*;
#(
  parameter int unsigned W      = DEFAULT_W,
  parameter int unsigned WINDOW = DEFAULT_WINDOW,
  parameter int unsigned CNT_W  = DEFAULT_CNT_W,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned IDX_W  = DEFAULT_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             m_en,
  output logic             m_clr,
  input  logic [W-1:0]     y_in,
  output logic [W-1:0]     res_data,
  output logic [IDX_W-1:0] res_idx,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] win_cnt
);

  localparam int unsigned    EW       = res_entry_w(W, IDX_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [EW-1:0]    head;

  assign last      = (cnt == LAST_CNT);
  assign pop       = res_valid & res_ready;
  assign m_en      = s_valid & s_ready;
  assign push      = m_en & last;
  assign res_valid = ~fifo_empty;
  assign res_data  = head[EW-1:IDX_W];
  assign res_idx   = head[IDX_W-1:0];
  assign win_cnt   = cnt;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_COLLECT;
    else      state <= state_nxt;
  end

  // Next state and gating; the last sample stalls only if the FIFO cannot take it this cycle.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_clr     = 1'b0;
    case (state)
      ST_COLLECT: begin
        s_ready = ~(last & fifo_full & ~pop);
        if (s_valid & s_ready & last) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        m_clr     = 1'b1;
        state_nxt = ST_COLLECT;
      end
    endcase
  end

  // Sample counter and window index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (m_en) begin
      if (last) begin
        cnt <= '0;
        idx <= idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Result queue of {window max, window index}.
  max_result_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .push_data ({y_in, idx}),
    .pop       (pop),
    .head_c    (head),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty)
  );

endmodule

// File: tb/tb_max_window_sink.sv
// Directed bench for max_window_sink with a behavioural running-max stage driving y_in.
module tb_max_window_sink;

  localparam int unsigned W      = 32;
  localparam int unsigned WINDOW = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned IDX_W  = 2;

  logic             clk;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic             m_en;
  logic             m_clr;
  logic [W-1:0]     y_in;
  logic [W-1:0]     res_data;
  logic [IDX_W-1:0] res_idx;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] win_cnt;

  logic [W-1:0]     cur;
  logic [W-1:0]     run;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int acc_cnt;
  int clr_cnt;
  int first_acc;
  int last_acc;
  logic [W-1:0]     pop_data [$];
  logic [IDX_W-1:0] pop_idx  [$];

  max_window_sink #(
    .W      (W),
    .WINDOW (WINDOW),
    .CNT_W  (CNT_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_en      (m_en),
    .m_clr     (m_clr),
    .y_in      (y_in),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .win_cnt   (win_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream running-max stage: y_in is the max including the current sample.
  assign y_in = (cur > run) ? cur : run;
  always @(posedge clk or negedge rst) begin
    if (!rst)       run <= '0;
    else if (m_clr) run <= '0;
    else if (m_en)  run <= y_in;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Observe accepts, clears and popped results.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt   <= 0;
      clr_cnt   <= 0;
      first_acc <= -1;
      last_acc  <= -1;
      pop_data.delete();
      pop_idx.delete();
    end else begin
      if (m_en) begin
        acc_cnt <= acc_cnt + 1;
        if (first_acc < 0) first_acc <= cyc;
        last_acc <= cyc;
      end
      if (m_clr) clr_cnt <= clr_cnt + 1;
      if (res_valid && res_ready) begin
        pop_data.push_back(res_data);
        pop_idx.push_back(res_idx);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic chk_pop(input string tag, input int i, input logic [W-1:0] ed,
                         input logic [IDX_W-1:0] ei);
    logic [W-1:0]     gd;
    logic [IDX_W-1:0] gi;
    gd = 'x;
    gi = 'x;
    if (i < pop_data.size()) begin
      gd = pop_data[i];
      gi = pop_idx[i];
    end
    check({tag, "_data"}, 64'(gd), 64'(ed));
    check({tag, "_idx"},  64'(gi), 64'(ei));
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    cur     = '0;
    rst     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and hold it until accepted (bounded wait).
  task automatic send(input logic [W-1:0] v);
    int waited = 0;
    cur     = v;
    s_valid = 1'b1;
    #2;
    while (!s_ready && waited < 20) begin
      @(posedge clk);
      #3;
      waited++;
    end
    check("send_ready", 64'(s_ready), 64'(1));
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    s_valid   = 1'b0;
    res_ready = 1'b1;
    cur       = '0;

    // Reset state
    #3;
    check("rst_valid", 64'(res_valid), 64'(0));
    check("rst_cnt",   64'(win_cnt),   64'(0));
    check("rst_clr",   64'(m_clr),     64'(0));
    check("rst_data",  64'(res_data),  64'(0));
    check("rst_idx",   64'(res_idx),   64'(0));
    #20 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_sready", 64'(s_ready), 64'(1));

    // 1: single window 5,9,3,7
    send(32'd5);
    send(32'd9);
    send(32'd3);
    check("t1_cnt3", 64'(win_cnt), 64'(3));
    cur     = 32'd7;
    s_valid = 1'b1;
    #2;
    check("t1_yin",      64'(y_in),      64'(9));
    check("t1_men",      64'(m_en),      64'(1));
    check("t1_pre_valid", 64'(res_valid), 64'(0));
    @(posedge clk);
    #1 s_valid = 1'b0;
    #1;
    check("t1_valid",  64'(res_valid), 64'(1));
    check("t1_data",   64'(res_data),  64'(9));
    check("t1_idx",    64'(res_idx),   64'(0));
    check("t1_clr",    64'(m_clr),     64'(1));
    check("t1_sready", 64'(s_ready),   64'(0));
    @(posedge clk);
    #2;
    check("t1_clr_end",  64'(m_clr),     64'(0));
    check("t1_sready1",  64'(s_ready),   64'(1));
    check("t1_popped",   64'(res_valid), 64'(0));
    check("t1_cnt0",     64'(win_cnt),   64'(0));
    check("t1_run0",     64'(run),       64'(0));

    // 2: three back-to-back windows
    do_reset();
    res_ready = 1'b1;
    for (int w = 0; w < 3; w++)
      for (int s = 0; s < 4; s++) send(W'(w * 10 + s + 1));
    repeat (2) @(posedge clk);
    #1;
    check("t2_acc",   64'(acc_cnt), 64'(12));
    check("t2_span",  64'(last_acc - first_acc), 64'(13));
    check("t2_clrs",  64'(clr_cnt), 64'(3));
    check("t2_npop",  64'(pop_data.size()), 64'(3));
    chk_pop("t2_r0", 0, 32'd4,  2'd0);
    chk_pop("t2_r1", 1, 32'd14, 2'd1);
    chk_pop("t2_r2", 2, 32'd24, 2'd2);

    // 3: back-pressure when the FIFO is full on the last sample
    do_reset();
    res_ready = 1'b0;
    send(32'd8); send(32'd2); send(32'd6); send(32'd1);
    send(32'd3); send(32'd30); send(32'd4); send(32'd5);
    send(32'd7); send(32'd7); send(32'd50);
    cur     = 32'd9;
    s_valid = 1'b1;
    #2;
    check("t3_stall",  64'(s_ready), 64'(0));
    check("t3_men0",   64'(m_en),    64'(0));
    repeat (3) @(posedge clk);
    #3;
    check("t3_hold_sready", 64'(s_ready),  64'(0));
    check("t3_hold_cnt",    64'(win_cnt),  64'(3));
    check("t3_hold_idx",    64'(res_idx),  64'(0));
    check("t3_hold_data",   64'(res_data), 64'(8));
    res_ready = 1'b1;
    #1;
    check("t3_release", 64'(s_ready), 64'(1));
    @(posedge clk);
    #1;
    s_valid   = 1'b0;
    res_ready = 1'b0;
    #1;
    check("t3_head_idx",  64'(res_idx),  64'(1));
    check("t3_head_data", 64'(res_data), 64'(30));
    check("t3_clr",       64'(m_clr),    64'(1));
    check("t3_npop1",     64'(pop_data.size()), 64'(1));
    res_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t3_npop",  64'(pop_data.size()), 64'(3));
    chk_pop("t3_r0", 0, 32'd8,  2'd0);
    chk_pop("t3_r1", 1, 32'd30, 2'd1);
    chk_pop("t3_r2", 2, 32'd50, 2'd2);
    check("t3_empty", 64'(res_valid), 64'(0));

    // 4: simultaneous pop and last-sample push while full
    do_reset();
    res_ready = 1'b0;
    send(32'd1); send(32'd2); send(32'd3); send(32'd4);
    send(32'd5); send(32'd6); send(32'd7); send(32'd8);
    send(32'd9); send(32'd10); send(32'd11);
    res_ready = 1'b1;
    send(32'd12);
    res_ready = 1'b0;
    #1;
    check("t4_valid", 64'(res_valid), 64'(1));
    check("t4_idx1",  64'(res_idx),   64'(1));
    check("t4_data1", 64'(res_data),  64'(8));
    check("t4_npop",  64'(pop_data.size()), 64'(1));
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    #1;
    check("t4_valid2", 64'(res_valid), 64'(1));
    check("t4_idx2",   64'(res_idx),   64'(2));
    check("t4_data2",  64'(res_data),  64'(12));
    res_ready = 1'b1;
    @(posedge clk);
    #2;
    check("t4_drained", 64'(res_valid), 64'(0));

    // 5: reset in the middle of a window
    do_reset();
    res_ready = 1'b1;
    send(32'd100);
    send(32'd200);
    check("t5_cnt2", 64'(win_cnt), 64'(2));
    #2 rst = 1'b0;
    #1;
    check("t5_cnt0",   64'(win_cnt),   64'(0));
    check("t5_valid0", 64'(res_valid), 64'(0));
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_sready", 64'(s_ready), 64'(1));
    send(32'd11); send(32'd12); send(32'd13); send(32'd14);
    repeat (2) @(posedge clk);
    #1;
    check("t5_npop", 64'(pop_data.size()), 64'(1));
    chk_pop("t5_r0", 0, 32'd14, 2'd0);

    // 6: all-ones data and index wrap
    do_reset();
    res_ready = 1'b1;
    send(32'd1); send(32'd2); send(32'd3); send(32'hFFFF_FFFF);
    for (int w = 1; w < 5; w++) begin
      send(W'(w));
      send(W'(2 * w));
      send(W'(100 * w));
      send(32'd3);
    end
    repeat (2) @(posedge clk);
    #1;
    check("t6_npop", 64'(pop_data.size()), 64'(5));
    chk_pop("t6_r0", 0, 32'hFFFF_FFFF, 2'd0);
    chk_pop("t6_r1", 1, 32'd100, 2'd1);
    chk_pop("t6_r2", 2, 32'd200, 2'd2);
    chk_pop("t6_r3", 3, 32'd300, 2'd3);
    chk_pop("t6_r4", 4, 32'd400, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
